// File: rtl/rx_pkg.sv
// Shared types and default timing parameters for the serial receive path.
package rx_pkg;

    typedef enum logic {IDLE, TRACK} rx_state_t;

    localparam int unsigned RX_BIT_PERIOD   = 8;
    localparam int unsigned RX_SAMPLE_POINT = 4;
    localparam int unsigned RX_MAX_RUN      = 6;

endpackage

// File: rtl/sync_high.sv
// Two-flop synchronizer for an asynchronous level that idles high.
module sync_high (
    input  logic clk,
    input  logic n_rst,
    input  logic d_in,
    output logic d_out
);

    logic s1;
    logic s2;

    // Capture the asynchronous input, then re-time it once more.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= d_in;
            s2 <= s1;
        end
    end

    assign d_out = s2;

endmodule

// File: rtl/rx_bit_sampler.sv
// Receive bit-timing recovery: re-phases a bit counter on each line transition,
// strobes one mid-bit sample per bit period and drops lock on over-long runs.
module rx_bit_sampler
    import rx_pkg::*;
#(
    parameter int unsigned BIT_PERIOD   = RX_BIT_PERIOD,
    parameter int unsigned SAMPLE_POINT = RX_SAMPLE_POINT,
    parameter int unsigned MAX_RUN      = RX_MAX_RUN
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable,
    input  logic d_in,
    output logic sample_valid,
    output logic sample_bit,
    output logic locked,
    output logic run_err
);

    localparam int unsigned PW = $clog2(BIT_PERIOD);
    localparam int unsigned RW = $clog2(MAX_RUN + 1);

    localparam logic [PW-1:0] PH_ONE    = PW'(1);
    localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_POINT);
    localparam logic [PW-1:0] PH_LAST   = PW'(BIT_PERIOD - 1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(MAX_RUN);

    logic          s2;
    logic          d_prev_q;
    logic          d_edge;
    logic [PW-1:0] phase_inc;

    rx_state_t     state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [RW-1:0] run_q, run_d;
    logic          valid_q, valid_d;
    logic          bit_q, bit_d;
    logic          err_q, err_d;
    logic          locked_q, locked_d;

    sync_high u_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d_in  (d_in),
        .d_out (s2)
    );

    // Previous synchronized level; runs regardless of enable.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            d_prev_q <= 1'b1;
        end else begin
            d_prev_q <= s2;
        end
    end

    assign d_edge    = s2 ^ d_prev_q;
    assign phase_inc = (phase_q == PH_LAST) ? '0 : phase_q + PH_ONE;

    // Next-state: lock acquisition, phase re-sync, sample/run-length decisions.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        run_d   = run_q;
        valid_d = 1'b0;
        bit_d   = bit_q;
        err_d   = 1'b0;

        if (!enable) begin
            // Disable beats any simultaneous edge or due sample.
            state_d = IDLE;
            phase_d = '0;
            run_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (d_edge) begin
                        state_d = TRACK;
                        phase_d = PH_ONE;
                        run_d   = '0;
                    end
                end
                TRACK: begin
                    if (d_edge) begin
                        // An edge in the sample cycle suppresses that sample.
                        phase_d = PH_ONE;
                        run_d   = '0;
                    end else if (phase_q == PH_SAMPLE) begin
                        if (run_q == RUN_MAX) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                            phase_d = '0;
                            run_d   = '0;
                        end else begin
                            valid_d = 1'b1;
                            bit_d   = s2;
                            run_d   = run_q + RW'(1);
                            phase_d = phase_inc;
                        end
                    end else begin
                        phase_d = phase_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    phase_d = '0;
                    run_d   = '0;
                end
            endcase
        end

        locked_d = (state_d == TRACK);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            run_q    <= '0;
            valid_q  <= 1'b0;
            bit_q    <= 1'b1;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            run_q    <= run_d;
            valid_q  <= valid_d;
            bit_q    <= bit_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    assign sample_valid = valid_q;
    assign sample_bit   = bit_q;
    assign locked       = locked_q;
    assign run_err      = err_q;

endmodule
